// File: rtl/winograd_pkg.sv
// Shared types and constants for the Winograd tile scheduler.
package winograd_pkg;

  // Fixed latency of the tile engine, in cycles.
  localparam int unsigned ENG_LAT    = 2;
  // Elements per operand tile and per result.
  localparam int unsigned TILE_ELEMS = 8;
  localparam int unsigned RES_ELEMS  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  // Result element width produced by the engine for a given operand-1 width.
  function automatic int unsigned out_w_f(input int unsigned in_size_1);
    return ((in_size_1 + 1) * 2) + 3;
  endfunction

endpackage

// File: rtl/winograd_sched_fifo.sv
// Synchronous result FIFO: flop storage, head read straight from the flops,
// no fall-through (a pushed entry becomes visible the cycle after the push).
module winograd_sched_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 42
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO or a pop from an empty one is dropped.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/winograd_sched.sv
// Job-level scheduler for the Winograd tile engine: issues N operand tiles to
// the fixed-latency engine, buffers results in a credit-protected FIFO and
// returns them in order with a last flag and a done pulse.
// Optional build macro: WINOGRAD_SCHED_PERF_EN enables the busy/stall counters.
module winograd_sched
  import winograd_pkg::*;
#(
  parameter int unsigned IN_SIZE_0  = 4,
  parameter int unsigned IN_SIZE_1  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned OUT_W     = out_w_f(IN_SIZE_1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     num_tiles_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [IN_SIZE_0-1:0] in_0_i     [0:TILE_ELEMS-1],
  input  logic [IN_SIZE_1-1:0] in_1_i     [0:TILE_ELEMS-1],
  output logic [IN_SIZE_0-1:0] eng_in_0_o [0:TILE_ELEMS-1],
  output logic [IN_SIZE_1-1:0] eng_in_1_o [0:TILE_ELEMS-1],
  input  logic [OUT_W-1:0]     eng_out_i  [0:RES_ELEMS-1],
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [OUT_W-1:0]     out_data_o [0:RES_ELEMS-1],
  output logic                 out_last_o,
  output logic [31:0]          perf_busy_o,
  output logic [31:0]          perf_stall_o
);

  localparam int unsigned FIFO_W = RES_ELEMS * OUT_W;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W  = FCNT_W + 1;

  sched_state_e      state_q;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  issue_cnt_q;
  logic [CNT_W-1:0]  issue_cnt_d;
  logic [CNT_W-1:0]  ret_cnt_q;
  logic              done_q;
  logic [ENG_LAT-1:0] inflight_q;

  logic              accept;
  logic [OCC_W-1:0]  occupancy;
  logic              fifo_push;
  logic              fifo_pop;
  logic [FIFO_W-1:0] fifo_wdata;
  logic [FIFO_W-1:0] fifo_rdata;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  // Credits: every accepted tile holds a slot from accept until its pop.
  always_comb begin
    occupancy = OCC_W'(fifo_count);
    for (int i = 0; i < int'(ENG_LAT); i++) begin
      occupancy = occupancy + OCC_W'(inflight_q[i]);
    end
  end

  // fifo_full cannot rise while occupancy < depth; it stays as a structural guard.
  assign in_ready_o  = (state_q == RUN) && (occupancy < OCC_W'(FIFO_DEPTH)) && !fifo_full;
  assign accept      = in_valid_i & in_ready_o;
  assign issue_cnt_d = issue_cnt_q + CNT_W'(1);

  // Operands reach the engine only in accept cycles; zeros otherwise.
  always_comb begin
    for (int i = 0; i < int'(TILE_ELEMS); i++) begin
      eng_in_0_o[i] = accept ? in_0_i[i] : '0;
      eng_in_1_o[i] = accept ? in_1_i[i] : '0;
    end
  end

  // Tracks which engine pipeline stages hold a live result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= {inflight_q[ENG_LAT-2:0], accept};
    end
  end

  assign fifo_push  = inflight_q[ENG_LAT-1];
  assign fifo_wdata = {eng_out_i[0], eng_out_i[1]};
  assign fifo_pop   = out_valid_o & out_ready_i;

  winograd_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid_o   = !fifo_empty;
  assign out_data_o[0] = fifo_rdata[FIFO_W-1 -: OUT_W];
  assign out_data_o[1] = fifo_rdata[OUT_W-1:0];
  assign out_last_o    = out_valid_o && (ret_cnt_q == (n_q - CNT_W'(1)));
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;

  // Job FSM with issue/return counters and the done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      n_q         <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (fifo_pop) begin
        ret_cnt_q <= ret_cnt_q + CNT_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (num_tiles_i != '0) begin
              n_q         <= num_tiles_i;
              issue_cnt_q <= '0;
              ret_cnt_q   <= '0;
              state_q     <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            issue_cnt_q <= issue_cnt_d;
            if (issue_cnt_d == n_q) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (fifo_pop && out_last_o) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef WINOGRAD_SCHED_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;
  logic        stall;

  assign stall = (state_q == RUN) && in_valid_i && !in_ready_o;

  // Saturating busy/stall counters, restarted by each accepted start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else if ((state_q == IDLE) && start_i) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy_o && (perf_busy_q != '1)) begin
        perf_busy_q <= perf_busy_q + 32'd1;
      end
      if (stall && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_busy_o  = perf_busy_q;
  assign perf_stall_o = perf_stall_q;
`else
  assign perf_busy_o  = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_winograd_sched.sv
// Self-checking bench for winograd_sched: a behavioural engine plus a
// transaction-level model (credits, per-tile timestamps, job bookkeeping).
module tb_winograd_sched;

  localparam int unsigned IN0   = 4;
  localparam int unsigned IN1   = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 16;
  localparam int unsigned OW    = ((IN1 + 1) * 2) + 3;
  localparam int unsigned RW    = 2 * OW;

  logic            clk_i;
  logic            rst_ni;
  logic            start_i;
  logic [CW-1:0]   num_tiles_i;
  logic            busy_o;
  logic            done_o;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [IN0-1:0]  in_0_i     [0:7];
  logic [IN1-1:0]  in_1_i     [0:7];
  logic [IN0-1:0]  eng_in_0_o [0:7];
  logic [IN1-1:0]  eng_in_1_o [0:7];
  logic [OW-1:0]   eng_out_i  [0:1];
  logic            out_valid_o;
  logic            out_ready_i;
  logic [OW-1:0]   out_data_o [0:1];
  logic            out_last_o;
  logic [31:0]     perf_busy_o;
  logic [31:0]     perf_stall_o;

  winograd_sched #(
    .IN_SIZE_0  (IN0),
    .IN_SIZE_1  (IN1),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .num_tiles_i  (num_tiles_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_0_i       (in_0_i),
    .in_1_i       (in_1_i),
    .eng_in_0_o   (eng_in_0_o),
    .eng_in_1_o   (eng_in_1_o),
    .eng_out_i    (eng_out_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_last_o   (out_last_o),
    .perf_busy_o  (perf_busy_o),
    .perf_stall_o (perf_stall_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Engine transfer function: two 4-term dot products.
  function automatic logic [RW-1:0] golden(input logic [IN0-1:0] a [0:7],
                                           input logic [IN1-1:0] b [0:7]);
    int unsigned s0;
    int unsigned s1;
    s0 = 0;
    s1 = 0;
    for (int k = 0; k < 4; k++) begin
      s0 += 32'(a[k]) * 32'(b[k]);
      s1 += 32'(a[k+4]) * 32'(b[k+4]);
    end
    return {OW'(s0), OW'(s1)};
  endfunction

  function automatic logic [8*IN0-1:0] pack0(input logic [IN0-1:0] a [0:7]);
    logic [8*IN0-1:0] r;
    for (int k = 0; k < 8; k++) r[k*IN0 +: IN0] = a[k];
    return r;
  endfunction

  function automatic logic [8*IN1-1:0] pack1(input logic [IN1-1:0] a [0:7]);
    logic [8*IN1-1:0] r;
    for (int k = 0; k < 8; k++) r[k*IN1 +: IN1] = a[k];
    return r;
  endfunction

  // Behavioural engine: fixed two-cycle latency, shares the reset.
  logic [RW-1:0] eng_s1, eng_s2;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eng_s1 <= '0;
      eng_s2 <= '0;
    end else begin
      eng_s1 <= golden(eng_in_0_o, eng_in_1_o);
      eng_s2 <= eng_s1;
    end
  end
  assign eng_out_i[0] = eng_s2[RW-1:OW];
  assign eng_out_i[1] = eng_s2[OW-1:0];

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  typedef struct {
    logic [RW-1:0] d;
    int            t;
  } exp_t;
  exp_t        q[$];
  int          cyc = 0;
  bit          m_active = 0;
  int          m_n = 0, m_issued = 0, m_returned = 0;
  bit          m_done_nxt = 0;
  logic [31:0] m_pbusy = 0, m_pstall = 0;
  int          acc_cnt = 0, pop_cnt = 0, last_cnt = 0, done_cnt = 0;
  int          first_acc = -1, last_acc = 0, last_pop = 0;

  // Compare all outputs for the current cycle, then advance the model.
  task automatic monitor();
    bit exp_ready, acc, exp_valid, pop, start_acc, nxt_done;
    exp_ready = m_active && (m_issued < m_n) && ((m_issued - m_returned) < int'(DEPTH));
    acc       = in_valid_i && exp_ready;
    exp_valid = (q.size() > 0) && (q[0].t + 3 <= cyc);
    check_eq("in_ready", 64'(in_ready_o), 64'(exp_ready));
    check_eq("busy", 64'(busy_o), 64'(m_active));
    check_eq("done", 64'(done_o), 64'(m_done_nxt));
    check_eq("eng_in_0", 64'(pack0(eng_in_0_o)), acc ? 64'(pack0(in_0_i)) : 64'(0));
    check_eq("eng_in_1", 64'(pack1(eng_in_1_o)), acc ? 64'(pack1(in_1_i)) : 64'(0));
    check_eq("out_valid", 64'(out_valid_o), 64'(exp_valid));
    pop = 1'b0;
    if (exp_valid) begin
      check_eq("out_data", 64'({out_data_o[0], out_data_o[1]}), 64'(q[0].d));
      check_eq("out_last", 64'(out_last_o), 64'(m_returned == m_n - 1));
      pop = out_ready_i;
    end
`ifdef WINOGRAD_SCHED_PERF_EN
    check_eq("perf_busy", 64'(perf_busy_o), 64'(m_pbusy));
    check_eq("perf_stall", 64'(perf_stall_o), 64'(m_pstall));
`else
    check_eq("perf_tied", 64'({perf_busy_o, perf_stall_o}), 64'(0));
`endif
    done_cnt += int'(done_o);
    if (exp_valid && pop && out_last_o) last_cnt++;
    nxt_done  = 1'b0;
    start_acc = !m_active && start_i;
    if (start_acc) begin
      m_pbusy  = 0;
      m_pstall = 0;
    end else begin
      if (m_active && m_pbusy != 32'hFFFF_FFFF) m_pbusy++;
      if (m_active && (m_issued < m_n) && in_valid_i && !exp_ready && m_pstall != 32'hFFFF_FFFF)
        m_pstall++;
    end
    if (acc) begin
      q.push_back('{d: golden(in_0_i, in_1_i), t: cyc});
      m_issued++;
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    if (pop) begin
      void'(q.pop_front());
      m_returned++;
      pop_cnt++;
      last_pop = cyc;
      if (m_returned == m_n) begin
        m_active = 1'b0;
        nxt_done = 1'b1;
      end
    end
    if (start_acc) begin
      if (num_tiles_i != '0) begin
        m_active   = 1'b1;
        m_n        = int'(num_tiles_i);
        m_issued   = 0;
        m_returned = 0;
      end else begin
        nxt_done = 1'b1;
      end
    end
    m_done_nxt = nxt_done;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk_i);
    monitor();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rand_data();
    for (int k = 0; k < 8; k++) begin
      in_0_i[k] = IN0'($urandom);
      in_1_i[k] = IN1'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    num_tiles_i = '0;
    q.delete();
    m_active   = 0;
    m_n        = 0;
    m_issued   = 0;
    m_returned = 0;
    m_done_nxt = 0;
    m_pbusy    = 0;
    m_pstall   = 0;
    step();
    check_eq("rst_out_data", 64'({out_data_o[0], out_data_o[1]}), 64'(0));
    check_eq("rst_out_last", 64'(out_last_o), 64'(0));
    check_eq("rst_perf", 64'({perf_busy_o, perf_stall_o}), 64'(0));
    step();
    rst_ni = 1'b1;
  endtask

  // Start a job and run it to completion with the given valid/ready rates.
  task automatic run_job(input int n, input int vpct, input int rpct,
                         input bit poke_start, input bit randomize_data);
    int k;
    start_i     = 1'b1;
    num_tiles_i = CW'(n);
    in_valid_i  = 1'b0;
    step();
    start_i = 1'b0;
    for (k = 0; k < 20000 && m_active; k++) begin
      if (randomize_data) rand_data();
      in_valid_i  = ($urandom_range(99) < vpct);
      out_ready_i = ($urandom_range(99) < rpct);
      start_i     = poke_start && ($urandom_range(9) == 0);
      num_tiles_i = CW'($urandom_range(5, 1));
      step();
    end
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    check_eq("job_timeout", 64'(m_active), 64'(0));
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, p0, l0, d0;
    rand_data();
    do_reset();

    // Single tile, constant operands.
    for (int k = 0; k < 8; k++) begin
      in_0_i[k] = IN0'(1);
      in_1_i[k] = IN1'(2);
    end
    a0 = acc_cnt; p0 = pop_cnt; l0 = last_cnt; d0 = done_cnt;
    run_job(1, 100, 100, 0, 0);
    check_eq("single_accepts", 64'(acc_cnt - a0), 64'(1));
    check_eq("single_latency", 64'(last_pop - last_acc), 64'(3));
    check_eq("single_last", 64'(last_cnt - l0), 64'(1));
    check_eq("single_done", 64'(done_cnt - d0), 64'(1));

    // Zero-length job.
    a0 = acc_cnt; d0 = done_cnt;
    run_job(0, 100, 100, 0, 1);
    check_eq("zero_accepts", 64'(acc_cnt - a0), 64'(0));
    check_eq("zero_done", 64'(done_cnt - d0), 64'(1));

    // Full-rate streaming.
    a0 = acc_cnt; p0 = pop_cnt; l0 = last_cnt; d0 = done_cnt; first_acc = -1;
    run_job(64, 100, 100, 0, 1);
    check_eq("stream_accepts", 64'(acc_cnt - a0), 64'(64));
    check_eq("stream_span", 64'(last_acc - first_acc), 64'(63));
    check_eq("stream_pops", 64'(pop_cnt - p0), 64'(64));
    check_eq("stream_last", 64'(last_cnt - l0), 64'(1));
    check_eq("stream_done", 64'(done_cnt - d0), 64'(1));

    // Backpressure: output held off for 20 cycles, start poked while busy.
    a0 = acc_cnt; p0 = pop_cnt; d0 = done_cnt;
    start_i = 1'b1; num_tiles_i = CW'(10); in_valid_i = 1'b0;
    step();
    start_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rand_data();
      in_valid_i  = 1'b1;
      out_ready_i = 1'b0;
      start_i     = (k == 5);
      num_tiles_i = CW'(7);
      step();
    end
    start_i = 1'b0;
    check_eq("bp_accepts", 64'(acc_cnt - a0), 64'(4));
    check_eq("bp_ready_low", 64'(in_ready_o), 64'(0));
    for (int k = 0; k < 200 && m_active; k++) begin
      rand_data();
      in_valid_i  = 1'b1;
      out_ready_i = 1'b1;
      step();
    end
    in_valid_i = 1'b0;
    step();
    check_eq("bp_pops", 64'(pop_cnt - p0), 64'(10));
    check_eq("bp_done", 64'(done_cnt - d0), 64'(1));

    // Random valid/ready with ignored start pokes.
    p0 = pop_cnt; d0 = done_cnt;
    run_job(200, 50, 50, 1, 1);
    check_eq("rand_pops", 64'(pop_cnt - p0), 64'(200));
    check_eq("rand_done", 64'(done_cnt - d0), 64'(1));

    // Reset in the middle of DRAIN, then a fresh job.
    start_i = 1'b1; num_tiles_i = CW'(6); in_valid_i = 1'b0;
    step();
    start_i = 1'b0;
    for (int k = 0; k < 100 && m_issued < 6; k++) begin
      rand_data();
      in_valid_i  = 1'b1;
      out_ready_i = 1'b1;
      step();
    end
    in_valid_i = 1'b0;
    do_reset();
    p0 = pop_cnt; d0 = done_cnt;
    run_job(3, 100, 100, 0, 1);
    check_eq("post_rst_pops", 64'(pop_cnt - p0), 64'(3));
    check_eq("post_rst_done", 64'(done_cnt - d0), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/winograd_sched.md
# winograd_sched

Job-level scheduler for the Winograd tile engine. It accepts a job of N operand tiles from an upstream valid/ready stream and issues them to the engine, which has fixed 2-cycle latency and no stall input. It tracks results in flight, buffers them in a credit-protected output FIFO, and returns them on a downstream valid/ready stream with a last flag and a done pulse. It sits between the tile loader and the result writer, and instantiates nothing but its FIFO. The engine is a sibling in the parent.

## Interface
Parameters:
- IN_SIZE_0, 4, width of each operand-0 element.
- IN_SIZE_1, 8, width of each operand-1 element.
- FIFO_DEPTH, 4, result FIFO entries; legal values are powers of 2 and at least 4.
- CNT_W, 16, width of the tile counter.
- OUT_W, derived (not overridable), result element width: ((IN_SIZE_1+1)*2)+3.

Ports:
- clk_i  in  1  the single clock.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  job start pulse; sampled only in IDLE.
- num_tiles_i  in  CNT_W  tile count; sampled together with start_i.
- busy_o  out  1  high while not IDLE.
- done_o  out  1  one-cycle job-complete pulse.
- in_valid_i  in  1  upstream operand valid.
- in_ready_o  out  1  upstream operand ready.
- in_0_i  in  IN_SIZE_0 x [0:7]  operand-0 tile.
- in_1_i  in  IN_SIZE_1 x [0:7]  operand-1 tile.
- eng_in_0_o  out  IN_SIZE_0 x [0:7]  operand 0 driven to the engine.
- eng_in_1_o  out  IN_SIZE_1 x [0:7]  operand 1 driven to the engine.
- eng_out_i  in  OUT_W x [0:1]  engine result.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result ready.
- out_data_o  out  OUT_W x [0:1]  result pair.
- out_last_o  out  1  marks the final result of the job.
- perf_busy_o  out  32  busy-cycle counter.
- perf_stall_o  out  32  input-stall counter.

## Operation
- FSM states are IDLE, RUN and DRAIN.
- IDLE, start_i=1, num_tiles_i>0: latch N; clear the issue and return counters; go to RUN.
- IDLE, start_i=1, num_tiles_i=0: pulse done_o in the next cycle and stay in IDLE.
- start_i is ignored outside IDLE.
- Accept condition is in_valid_i & in_ready_o.
- On an accepted cycle, eng_in_*_o = in_*_i combinationally. In every other cycle eng_in_*_o is all zeros.
- In-flight pipe is a 2-bit shift register: v[0] is set on the accept edge, and v[1] follows v[0].
- When v[1]=1, eng_out_i is written into the FIFO at the end of that cycle.
- Occupancy = fifo_count + v[0] + v[1].
- in_ready_o = (state==RUN) & (occupancy < FIFO_DEPTH). This guarantees the FIFO never overflows, so no engine result is ever dropped.
- RUN moves to DRAIN on the accept that makes the issue count equal to N.
- The return counter increments on each out handshake.
- out_last_o = out_valid_o & (return count == N-1).
- DRAIN moves to IDLE on the handshake of the last result. done_o pulses in the following cycle.
- Results are returned strictly in issue order. out_data_o is the FIFO head.

## Timing
- Reset values: every output is 0, including eng_in_*_o and the perf counters. FSM is IDLE; v=0; FIFO is empty; all counters are 0.
- Latency: accept in cycle n gives eng_out_i valid in cycle n+2 and out_valid_o in cycle n+3.
- Throughput is 1 tile/cycle while out_ready_i=1.
- Backpressure: with out_ready_i held 0, at most FIFO_DEPTH tiles are accepted in total. in_ready_o then stays 0 until a pop frees space.
- Simultaneous FIFO push and pop in one cycle is legal; the count is unchanged.
- A pop while the FIFO is empty cannot occur, because out_valid_o gates it.
- Reset mid-job: returns immediately to the reset state. In-flight results are discarded; the engine shares rst_ni.
- Counters do not wrap: N ≤ 2^CNT_W - 1 is enforced by the port width.

## Configuration
- Macro: WINOGRAD_SCHED_PERF_EN.
- When defined:
  - perf_busy_o counts cycles with busy_o=1.
  - perf_stall_o counts cycles with state==RUN & in_valid_i & !in_ready_o.
  - Both counters are 32-bit, saturating, and cleared on an accepted start_i.
- When undefined: both ports are tied to 0 and no counter flops are built. The port list is identical in both builds.

## Structure
- winograd_pkg holds:
  - ENG_LAT = 2.
  - The sched_state_e enum (IDLE, RUN, DRAIN).
  - A function returning OUT_W from IN_SIZE_1.
- One sub-module: winograd_sched_fifo.
  - Synchronous FIFO with parameters DEPTH and WIDTH, where WIDTH = 2*OUT_W.
  - Outputs count, full and empty; data is registered; no fall-through.

## Test plan
- Single tile: start with N=1, in_0 all 1s, in_1 all 2s, out_ready=1 → out_valid in cycle accept+3 equals the golden-model result, with out_last=1 and done_o one cycle after the handshake.
- Streaming: N=64, in_valid=1, out_ready=1 → 64 accepts in 64 consecutive cycles, 64 in-order results, exactly one out_last, done_o once.
- Backpressure: N=10, out_ready=0 → exactly 4 accepts, then in_ready=0 indefinitely. Raising out_ready → all 10 results in order with no loss.
- Random stalls: N=200 with random in_valid and out_ready at 50% → scoreboard matches, FIFO never overflows, eng_in_*_o is zero on every non-accept cycle.
- Edge cases:
  - N=0 → done_o one cycle later, no accepts.
  - start_i while busy → ignored.
  - rst_ni asserted mid-DRAIN → all outputs are 0 and a subsequent N=3 job completes correctly.
- With WINOGRAD_SCHED_PERF_EN defined, N=10 and out_ready=0 for 20 cycles → perf_stall_o and perf_busy_o match the cycle-accurate model.
